hmac_tx_append: RTL and testbench

Transmit-side counterpart of the receive-path metadata/HMAC checker. For each host packet, the block:
- prepends one metadata header beat (FPGA_ID, CONNECTION_ID, per-packet counter);
- forwards header and body beats both to the link and to an external hmac core;
- appends the returned HMAC as a single trailer beat carrying tlast.
It sits between the host input FIFO and the outgoing network/host FIFO.

---
 rtl/hmac_tx_append.sv | 202 ++++++++++++++++++++
 tb/tb_hmac_tx_append.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hmac_tx_append.sv
// hmac_tx_append: transmit-side framing for authenticated packets.
//
// For each host packet this block emits, on the link (m_axis):
//   1. one metadata header beat {counter, CONNECTION_ID, FPGA_ID},
//   2. the packet body beats (tlast forced low),
//   3. one trailer beat carrying the HMAC returned by the external core (tlast high).
// The header and body beats are also delivered to the hmac core (hmac_in), with tlast on the
// final body beat only.
//
// Ports:
//   aclk, areset          clock, asynchronous active-high reset
//   s_axis_*              host packet stream in
//   m_axis_*              framed output stream
//   hmac_in_*             header + body stream to the hmac core
//   hmac_out_*            one HMAC result beat per packet from the core
//   pkt_counter           counter value carried by the next header
module hmac_tx_append #(
    parameter int unsigned DATA_W                = 512,
    parameter int unsigned ID_W                  = 6,
    parameter logic [63:0] FPGA_ID               = 64'hC0FFEE0123456789,
    parameter logic [63:0] CONNECTION_ID         = 64'hDEADBEEF98765432,
    parameter logic [63:0] INITIAL_COUNTER_VALUE = 64'h0
) (
    input  logic                aclk,
    input  logic                areset,

    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic [ID_W-1:0]     s_axis_tid,
    input  logic                s_axis_tlast,

    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic [ID_W-1:0]     m_axis_tid,
    output logic                m_axis_tlast,

    output logic                hmac_in_tvalid,
    input  logic                hmac_in_tready,
    output logic [DATA_W-1:0]   hmac_in_tdata,
    output logic [DATA_W/8-1:0] hmac_in_tkeep,
    output logic [ID_W-1:0]     hmac_in_tid,
    output logic                hmac_in_tlast,

    input  logic                hmac_out_tvalid,
    output logic                hmac_out_tready,
    input  logic [DATA_W-1:0]   hmac_out_tdata,

    output logic [63:0]         pkt_counter
);

    localparam int unsigned KEEP_W = DATA_W / 8;

    typedef enum logic [1:0] {
        StHdr,
        StBody,
        StWaitMac,
        StTrail
    } state_e;

    state_e              state_q, state_d;

    // Single beat register shared by both consumers; each has its own pending flag.
    logic [DATA_W-1:0]   data_q, data_d;
    logic [KEEP_W-1:0]   keep_q, keep_d;
    logic [ID_W-1:0]     tid_q, tid_d;
    logic                last_m_q, last_m_d;
    logic                last_h_q, last_h_d;
    logic                pend_m_q, pend_m_d;
    logic                pend_h_q, pend_h_d;

    logic [ID_W-1:0]     pkt_tid_q, pkt_tid_d;
    logic [63:0]         counter_q, counter_d;

    logic                m_hs;
    logic                h_hs;
    logic                loadable;
    logic [DATA_W-1:0]   header;

    always_comb begin
        m_hs     = pend_m_q & m_axis_tready;
        h_hs     = pend_h_q & hmac_in_tready;
        // Loadable when every pending copy is either absent or leaving this cycle.
        loadable = (~pend_m_q | m_hs) & (~pend_h_q | h_hs);

        header          = '0;
        header[63:0]    = FPGA_ID;
        header[127:64]  = CONNECTION_ID;
        header[191:128] = counter_q;

        state_d         = state_q;
        data_d          = data_q;
        keep_d          = keep_q;
        tid_d           = tid_q;
        last_m_d        = last_m_q;
        last_h_d        = last_h_q;
        pend_m_d        = pend_m_q & ~m_hs;
        pend_h_d        = pend_h_q & ~h_hs;
        pkt_tid_d       = pkt_tid_q;
        counter_d       = counter_q;
        s_axis_tready   = 1'b0;
        hmac_out_tready = 1'b0;

        case (state_q)
            StHdr: begin
                // The first body beat is only observed here, not consumed.
                if (s_axis_tvalid && loadable) begin
                    data_d    = header;
                    keep_d    = '1;
                    tid_d     = s_axis_tid;
                    pkt_tid_d = s_axis_tid;
                    last_m_d  = 1'b0;
                    last_h_d  = 1'b0;
                    pend_m_d  = 1'b1;
                    pend_h_d  = 1'b1;
                    state_d   = StBody;
                end
            end
            StBody: begin
                s_axis_tready = loadable;
                if (s_axis_tvalid && loadable) begin
                    data_d   = s_axis_tdata;
                    keep_d   = s_axis_tkeep;
                    tid_d    = s_axis_tid;
                    last_m_d = 1'b0;
                    last_h_d = s_axis_tlast;
                    pend_m_d = 1'b1;
                    pend_h_d = 1'b1;
                    if (s_axis_tlast) begin
                        state_d = StWaitMac;
                    end
                end
            end
            StWaitMac: begin
                // Uses the registered flags so the MAC never overtakes the last body beat.
                hmac_out_tready = ~pend_m_q & ~pend_h_q;
                if (hmac_out_tvalid && ~pend_m_q && ~pend_h_q) begin
                    data_d   = hmac_out_tdata;
                    keep_d   = '1;
                    tid_d    = pkt_tid_q;
                    last_m_d = 1'b1;
                    last_h_d = 1'b0;
                    pend_m_d = 1'b1;
                    state_d  = StTrail;
                end
            end
            StTrail: begin
                if (m_hs) begin
                    counter_d = counter_q + 64'd1;
                    state_d   = StHdr;
                end
            end
            default: begin
                state_d = StHdr;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= StHdr;
            data_q    <= '0;
            keep_q    <= '0;
            tid_q     <= '0;
            last_m_q  <= 1'b0;
            last_h_q  <= 1'b0;
            pend_m_q  <= 1'b0;
            pend_h_q  <= 1'b0;
            pkt_tid_q <= '0;
            counter_q <= INITIAL_COUNTER_VALUE;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            tid_q     <= tid_d;
            last_m_q  <= last_m_d;
            last_h_q  <= last_h_d;
            pend_m_q  <= pend_m_d;
            pend_h_q  <= pend_h_d;
            pkt_tid_q <= pkt_tid_d;
            counter_q <= counter_d;
        end
    end

    assign m_axis_tvalid  = pend_m_q;
    assign m_axis_tdata   = data_q;
    assign m_axis_tkeep   = keep_q;
    assign m_axis_tid     = tid_q;
    assign m_axis_tlast   = last_m_q;

    assign hmac_in_tvalid = pend_h_q;
    assign hmac_in_tdata  = data_q;
    assign hmac_in_tkeep  = keep_q;
    assign hmac_in_tid    = tid_q;
    assign hmac_in_tlast  = last_h_q;

    assign pkt_counter    = counter_q;

endmodule

// File: tb/tb_hmac_tx_append.sv
// Testbench for hmac_tx_append: packet-level reference model with expected-beat queues for
// both output streams, a table of directed packets, randomized backpressure, early-MAC,
// mid-packet reset and counter-wrap (second instance) sequences.
module tb_hmac_tx_append;

    localparam int          DW    = 512;
    localparam int          KW    = 64;
    localparam int          IW    = 6;
    localparam logic [63:0] FPGA  = 64'hC0FFEE0123456789;
    localparam logic [63:0] CONN  = 64'hDEADBEEF98765432;
    localparam logic [63:0] INIT0 = 64'h0;
    localparam logic [63:0] INIT1 = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [IW-1:0] id;
        logic          l;
    } beat_t;

    typedef struct {
        int            n;
        logic [IW-1:0] tid;
        logic [KW-1:0] klast;
        int            fill;
        int            mpct;
        int            hpct;
        int            mdly;
        int            exp_m;
        int            exp_h;
        logic [63:0]   exp_ctr;
    } vec_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;

    logic s_tvalid, s_tready, s_tlast;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [IW-1:0] s_tid;
    logic m_tvalid, m_tready, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [IW-1:0] m_tid;
    logic h_tvalid, h_tready, h_tlast;
    logic [DW-1:0] h_tdata;
    logic [KW-1:0] h_tkeep;
    logic [IW-1:0] h_tid;
    logic ho_tvalid, ho_tready;
    logic [DW-1:0] ho_tdata;
    logic [63:0] pkt_counter;

    // Second instance: counter wrap from all-ones.
    logic s1_tvalid, s1_tready, s1_tlast;
    logic [DW-1:0] s1_tdata;
    logic [KW-1:0] s1_tkeep;
    logic [IW-1:0] s1_tid;
    logic m1_tvalid, m1_tready, m1_tlast;
    logic [DW-1:0] m1_tdata;
    logic [KW-1:0] m1_tkeep;
    logic [IW-1:0] m1_tid;
    logic h1_tvalid, h1_tready, h1_tlast;
    logic [DW-1:0] h1_tdata;
    logic [KW-1:0] h1_tkeep;
    logic [IW-1:0] h1_tid;
    logic ho1_tvalid, ho1_tready;
    logic [DW-1:0] ho1_tdata;
    logic [63:0] pkt_counter1;

    hmac_tx_append #(.INITIAL_COUNTER_VALUE(INIT0)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tid(s_tid), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep), .m_axis_tid(m_tid), .m_axis_tlast(m_tlast),
        .hmac_in_tvalid(h_tvalid), .hmac_in_tready(h_tready), .hmac_in_tdata(h_tdata),
        .hmac_in_tkeep(h_tkeep), .hmac_in_tid(h_tid), .hmac_in_tlast(h_tlast),
        .hmac_out_tvalid(ho_tvalid), .hmac_out_tready(ho_tready), .hmac_out_tdata(ho_tdata),
        .pkt_counter(pkt_counter)
    );

    hmac_tx_append #(.INITIAL_COUNTER_VALUE(INIT1)) dut_wrap (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready), .s_axis_tdata(s1_tdata),
        .s_axis_tkeep(s1_tkeep), .s_axis_tid(s1_tid), .s_axis_tlast(s1_tlast),
        .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready), .m_axis_tdata(m1_tdata),
        .m_axis_tkeep(m1_tkeep), .m_axis_tid(m1_tid), .m_axis_tlast(m1_tlast),
        .hmac_in_tvalid(h1_tvalid), .hmac_in_tready(h1_tready), .hmac_in_tdata(h1_tdata),
        .hmac_in_tkeep(h1_tkeep), .hmac_in_tid(h1_tid), .hmac_in_tlast(h1_tlast),
        .hmac_out_tvalid(ho1_tvalid), .hmac_out_tready(ho1_tready), .hmac_out_tdata(ho1_tdata),
        .pkt_counter(pkt_counter1)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int m_pct = 100;
    int h_pct = 100;
    int mac_dly = 0;
    bit mac_early = 1'b0;
    int mac_pend = 0;
    int mac_hs_cyc = 0;
    int early_stall = 0;
    int m_cnt = 0;
    int h_cnt = 0;
    int h1_cnt = 0;
    bit start1 = 1'b1;
    int m_hs_cyc[$];
    beat_t exp_m[$];
    beat_t exp_h[$];
    logic [DW-1:0] mac_q[$];
    logic [63:0] hdr1[$];
    logic [63:0] model_ctr = INIT0;

    logic [DW-1:0] pkt_d[16];
    logic [KW-1:0] pkt_k[16];
    logic          pkt_l[16];
    logic [IW-1:0] pkt_tid;
    vec_t          vecs[4];

    task automatic chk(input string nm, input logic [599:0] act, input logic [599:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Expected streams for one packet, from the framing rules.
    task automatic build_pkt(input int n, input logic [IW-1:0] tid, input logic [KW-1:0] klast,
                             input int fill);
        beat_t b;
        logic [DW-1:0] mac;
        pkt_tid = tid;
        b = '0;
        b.d[63:0] = FPGA;
        b.d[127:64] = CONN;
        b.d[191:128] = model_ctr;
        b.k = '1;
        b.id = tid;
        exp_m.push_back(b);
        exp_h.push_back(b);
        model_ctr = model_ctr + 64'd1;
        for (int i = 0; i < n; i++) begin
            pkt_d[i] = (fill >= 0) ? {64{fill[7:0]}} : rand_word();
            pkt_k[i] = (i == n - 1) ? klast : '1;
            pkt_l[i] = (i == n - 1);
            b.d = pkt_d[i];
            b.k = pkt_k[i];
            b.l = 1'b0;
            exp_m.push_back(b);
            b.l = pkt_l[i];
            exp_h.push_back(b);
        end
        mac = rand_word();
        mac_q.push_back(mac);
        b.d = mac;
        b.k = '1;
        b.l = 1'b1;
        exp_m.push_back(b);
    endtask

    task automatic drive_beats(input int cnt);
        int to;
        s_tvalid = 1'b1;
        s_tid = pkt_tid;
        for (int i = 0; i < cnt; i++) begin
            s_tdata = pkt_d[i];
            s_tkeep = pkt_k[i];
            s_tlast = pkt_l[i];
            to = 0;
            do begin
                @(negedge aclk);
                to++;
            end while (!s_tready && to < 5000);
            if (!s_tready) begin
                chk("s_accept_timeout", 1'b0, 1'b1);
                break;
            end
            @(posedge aclk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [IW-1:0] tid, input logic [KW-1:0] klast,
                            input int fill);
        build_pkt(n, tid, klast, fill);
        drive_beats(n);
    endtask

    task automatic wait_done();
        int to = 0;
        while ((exp_m.size() != 0 || exp_h.size() != 0) && to < 5000) begin
            @(negedge aclk);
            to++;
        end
        chk("drain_timeout", (exp_m.size() == 0 && exp_h.size() == 0), 1'b1);
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        #1;
        chk("rst_valids", {m_tvalid, h_tvalid, s_tready, ho_tready}, 4'b0000);
        chk("rst_counter", pkt_counter, INIT0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        model_ctr = INIT0;
    endtask

    initial begin : cycle_count
        forever begin
            @(posedge aclk);
            cyc++;
        end
    end

    initial begin : ready_gen
        m_tready = 1'b0;
        h_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            m_tready = ($urandom_range(99) < m_pct);
            h_tready = ($urandom_range(99) < h_pct);
        end
    end

    initial begin : mac_responder
        int to;
        ho_tvalid = 1'b0;
        ho_tdata = '0;
        forever begin
            @(posedge aclk);
            #1;
            if (mac_q.size() > 0 && (mac_pend > 0 || mac_early)) begin
                if (!mac_early && mac_dly > 0) begin
                    repeat (mac_dly) @(posedge aclk);
                    #1;
                end
                ho_tvalid = 1'b1;
                ho_tdata = mac_q[0];
                to = 0;
                do begin
                    @(negedge aclk);
                    to++;
                end while (!ho_tready && to < 5000);
                if (!ho_tready) begin
                    chk("mac_accept_timeout", 1'b0, 1'b1);
                    if (mac_q.size() > 0) mac_q.pop_front();
                end
                @(posedge aclk);
                #1;
                ho_tvalid = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge aclk);
            // MAC may only be taken once the whole body has left on both streams.
            if (ho_tready) chk("mac_ready_gate", {m_tvalid, h_tvalid, mac_pend > 0}, 3'b001);
            if (ho_tvalid && !ho_tready && mac_early) early_stall++;
            if (m_tvalid && m_tready) begin
                m_cnt++;
                m_hs_cyc.push_back(cyc);
                if (exp_m.size() == 0) chk("m_extra_beat", 1'b1, 1'b0);
                else begin
                    chk("m_beat", {m_tdata, m_tkeep, m_tid, m_tlast}, exp_m[0]);
                    exp_m.pop_front();
                end
            end
            if (h_tvalid && h_tready) begin
                h_cnt++;
                if (h_tlast) mac_pend++;
                if (exp_h.size() == 0) chk("h_extra_beat", 1'b1, 1'b0);
                else begin
                    chk("h_beat", {h_tdata, h_tkeep, h_tid, h_tlast}, exp_h[0]);
                    exp_h.pop_front();
                end
            end
            if (ho_tvalid && ho_tready) begin
                mac_pend--;
                mac_hs_cyc = cyc;
                if (mac_q.size() > 0) mac_q.pop_front();
            end
        end
    end

    initial begin : monitor_wrap
        forever begin
            @(negedge aclk);
            if (m1_tvalid && m1_tready) begin
                if (start1) hdr1.push_back(m1_tdata[191:128]);
                start1 = m1_tlast;
            end
            if (h1_tvalid && h1_tready) h1_cnt++;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int to;
        int m0;
        int h0;
        s_tvalid = 0; s_tdata = '0; s_tkeep = '0; s_tid = '0; s_tlast = 0;
        s1_tvalid = 0; s1_tdata = '0; s1_tkeep = '0; s1_tid = '0; s1_tlast = 0;
        m1_tready = 1; h1_tready = 1; ho1_tvalid = 0; ho1_tdata = '0;

        vecs[0] = '{1, 3, {KW{1'b1}}, 'hAA, 100, 100, 2, 3, 2, 64'd1};
        vecs[1] = '{4, 9, 64'h0000_0000_0000_00FF, -1, 100, 100, 5, 6, 5, 64'd2};
        vecs[2] = '{3, 17, 64'h0000_0000_0000_0001, -1, 100, 100, 0, 5, 4, 64'd3};
        vecs[3] = '{2, 63, 64'h0000_FFFF_0000_FFFF, -1, 50, 70, 3, 4, 3, 64'd4};

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_valids", {m_tvalid, h_tvalid, s_tready, ho_tready}, 4'b0000);
        chk("rst_counter", pkt_counter, INIT0);
        chk("rst_data", m_tdata, '0);
        chk("rst_counter_wrap", pkt_counter1, INIT1);
        areset = 1'b0;
        @(posedge aclk);
        #1;

        // Counter wrap on the second instance: two single-beat packets.
        for (int p = 0; p < 2; p++) begin
            s1_tvalid = 1; s1_tlast = 1; s1_tdata = DW'(p + 1); s1_tkeep = '1; s1_tid = 6'd1;
            to = 0;
            do begin
                @(negedge aclk);
                to++;
            end while (!s1_tready && to < 100);
            chk("wrap_s_accept", s1_tready, 1'b1);
            @(posedge aclk);
            #1;
            s1_tvalid = 0;
            ho1_tvalid = 1;
            ho1_tdata = rand_word();
            to = 0;
            do begin
                @(negedge aclk);
                to++;
            end while (!ho1_tready && to < 100);
            chk("wrap_mac_accept", ho1_tready, 1'b1);
            @(posedge aclk);
            #1;
            ho1_tvalid = 0;
            repeat (3) @(posedge aclk);
            #1;
        end
        chk("wrap_hdr_count", hdr1.size(), 2);
        chk("wrap_hdr0", hdr1[0], INIT1);
        chk("wrap_hdr1", hdr1[1], 64'h0);
        chk("wrap_counter", pkt_counter1, 64'd1);
        chk("wrap_hmac_beats", h1_cnt, 4);

        // Directed packet table.
        for (int i = 0; i < 4; i++) begin
            m_pct = vecs[i].mpct;
            h_pct = vecs[i].hpct;
            mac_dly = vecs[i].mdly;
            m0 = m_cnt;
            h0 = h_cnt;
            m_hs_cyc.delete();
            send_pkt(vecs[i].n, vecs[i].tid, vecs[i].klast, vecs[i].fill);
            wait_done();
            chk("vec_m_beats", m_cnt - m0, vecs[i].exp_m);
            chk("vec_h_beats", h_cnt - h0, vecs[i].exp_h);
            chk("vec_counter", pkt_counter, vecs[i].exp_ctr);
            if (vecs[i].mpct == 100 && vecs[i].hpct == 100) begin
                chk("vec_no_bubble", m_hs_cyc[vecs[i].n] - m_hs_cyc[0], vecs[i].n);
                chk("vec_trailer_latency", m_hs_cyc[vecs[i].n + 1], mac_hs_cyc + 1);
            end
        end

        // MAC offered before and during the body.
        m_pct = 100;
        h_pct = 60;
        mac_early = 1'b1;
        early_stall = 0;
        send_pkt(4, 6'd5, {KW{1'b1}}, -1);
        wait_done();
        chk("early_mac_stalled", early_stall > 0, 1'b1);
        chk("early_counter", pkt_counter, 64'd5);
        mac_early = 1'b0;

        // Random packets under random backpressure; header counters 0..19.
        pulse_reset();
        m_pct = 50;
        h_pct = 70;
        for (int p = 0; p < 20; p++) begin
            mac_dly = $urandom_range(4);
            send_pkt($urandom_range(1, 6), IW'($urandom), {$urandom, $urandom} | 64'h1, -1);
        end
        wait_done();
        chk("rand_counter", pkt_counter, 64'd20);

        // Reset in the middle of a packet body.
        m_pct = 100;
        h_pct = 100;
        build_pkt(5, 6'd12, {KW{1'b1}}, -1);
        drive_beats(2);
        chk("pre_reset_valids", {m_tvalid, h_tvalid}, 2'b11);
        #2;
        areset = 1'b1;
        #1;
        chk("reset_valids", {m_tvalid, h_tvalid, s_tready, ho_tready}, 4'b0000);
        chk("reset_counter", pkt_counter, INIT0);
        exp_m.delete();
        exp_h.delete();
        mac_q.delete();
        mac_pend = 0;
        model_ctr = INIT0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        m0 = m_cnt;
        send_pkt(2, 6'd7, 64'h0000_0000_0000_000F, -1);
        wait_done();
        chk("post_reset_m_beats", m_cnt - m0, 4);
        chk("post_reset_counter", pkt_counter, 64'd1);
        chk("mac_queue_empty", mac_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
